fib_req_sequencer: RTL and testbench

// - Upstream request stage for the fib core: buffers n requests, drives go/n, collects result/overflow.
// - Presents each result on a valid/ready stream; one request in flight at a time, results in request order.

---
 rtl/fib_req_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_fib_req_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_req_sequencer.sv
// fib_req_sequencer: queues n requests, drives one fib core transaction at a
// time, and returns each result on a valid/ready stream in request order.
// Optional build macro FIB_SEQ_TIMEOUT_EN adds a watchdog that aborts a stuck
// request after TIMEOUT_CYCLES wait cycles. Without it, out_timeout is tied low.
module fib_req_sequencer #(
  parameter int unsigned INPUT_WIDTH    = 6,
  parameter int unsigned OUTPUT_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [INPUT_WIDTH-1:0]  i_in_n,
  output logic                    o_fib_go,
  output logic [INPUT_WIDTH-1:0]  o_fib_n,
  input  logic [OUTPUT_WIDTH-1:0] i_fib_result,
  input  logic                    i_fib_overflow,
  input  logic                    i_fib_done,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [OUTPUT_WIDTH-1:0] o_out_result,
  output logic                    o_out_overflow,
  output logic [INPUT_WIDTH-1:0]  o_out_n,
  output logic                    o_out_timeout
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Reject configurations the pointer arithmetic cannot handle
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1))
  begin : g_bad_cfg
    $error("fib_req_sequencer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [INPUT_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    r_in_ready;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_capture;
  logic                    w_abort;
  logic                    w_tmo_hit;
  logic                    w_fifo_nonempty;
  logic [INPUT_WIDTH-1:0]  r_n;
  logic                    r_fib_go;
  logic                    r_out_valid;
  logic [OUTPUT_WIDTH-1:0] r_out_result;
  logic                    r_out_overflow;
  logic [INPUT_WIDTH-1:0]  r_out_n;

  assign w_push          = i_in_valid && r_in_ready;
  assign w_fifo_nonempty = (r_count != '0);

  // Occupancy after this cycle's push/pop; a full FIFO never accepts a push
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Request FIFO storage, pointers and registered ready
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_in_n;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; WAIT_CLR skips the stale done left from the last result
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!i_fib_done) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_tmo_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_WAIT_DONE: begin
        if (i_fib_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (w_tmo_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_out_valid && i_out_ready) begin
          if (w_fifo_nonempty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Core-side registers: go is high exactly while the FSM sits in ISSUE
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_n      <= '0;
      r_fib_go <= 1'b0;
    end else begin
      if (w_pop) begin
        r_n <= r_mem[r_rd_ptr];
      end
      r_fib_go <= (w_state_nxt == S_ISSUE);
    end
  end

  // Response registers, held stable in HOLD until accepted
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_overflow <= 1'b0;
      r_out_n        <= '0;
    end else if (w_capture) begin
      r_out_valid    <= 1'b1;
      r_out_result   <= i_fib_result;
      r_out_overflow <= i_fib_overflow;
      r_out_n        <= r_n;
    end else if (w_abort) begin
      r_out_valid    <= 1'b1;
      r_out_result   <= '0;
      r_out_overflow <= 1'b0;
      r_out_n        <= r_n;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef FIB_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_out_timeout;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts wait cycles of the current request, restarts on ISSUE
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_tmo_cnt <= '0;
    end else if (((r_state == S_WAIT_CLR) || (r_state == S_WAIT_DONE)) && !w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Timeout flag: set by an abort, cleared by a normal response
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_out_timeout <= 1'b0;
    end else if (w_abort) begin
      r_out_timeout <= 1'b1;
    end else if (w_capture) begin
      r_out_timeout <= 1'b0;
    end
  end

  assign o_out_timeout = r_out_timeout;
`else
  assign w_tmo_hit     = 1'b0;
  assign o_out_timeout = 1'b0;
`endif

  assign o_in_ready     = r_in_ready;
  assign o_fib_go       = r_fib_go;
  assign o_fib_n        = r_n;
  assign o_out_valid    = r_out_valid;
  assign o_out_result   = r_out_result;
  assign o_out_overflow = r_out_overflow;
  assign o_out_n        = r_out_n;

endmodule

// File: tb/tb_fib_req_sequencer.sv
// Self-checking bench for fib_req_sequencer with a behavioural fib core stub.
// Build with FIB_SEQ_TIMEOUT_EN defined to also exercise the watchdog.
module tb_fib_req_sequencer;

  localparam int unsigned IW = 6;
  localparam int unsigned OW = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_n;
  logic          fib_go;
  logic [IW-1:0] fib_n;
  logic [OW-1:0] fib_result;
  logic          fib_overflow;
  logic          fib_done;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_result;
  logic          out_overflow;
  logic [IW-1:0] out_n;
  logic          out_timeout;

  fib_req_sequencer #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_n(in_n),
    .o_fib_go(fib_go), .o_fib_n(fib_n),
    .i_fib_result(fib_result), .i_fib_overflow(fib_overflow), .i_fib_done(fib_done),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_result(out_result), .o_out_overflow(out_overflow),
    .o_out_n(out_n), .o_out_timeout(out_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fib core stub: registers go, drops done one cycle later, finishes after
  // a short latency and keeps done high until the next go.
  logic          stub_hang;
  logic          stub_pending;
  logic          stub_busy;
  logic [2:0]    stub_lat;
  logic [IW-1:0] stub_n;

  function automatic logic [63:0] fib64(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int k = 0; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      stub_pending <= 1'b0;
      stub_busy    <= 1'b0;
      stub_lat     <= 3'd0;
      stub_n       <= '0;
      fib_done     <= 1'b0;
      fib_result   <= '0;
      fib_overflow <= 1'b0;
    end else begin
      stub_pending <= fib_go;
      if (fib_go) stub_n <= fib_n;
      if (stub_pending) begin
        fib_done  <= 1'b0;
        stub_busy <= !stub_hang;
        stub_lat  <= 3'd3;
      end else if (stub_busy) begin
        if (stub_lat == 3'd0) begin
          fib_done     <= 1'b1;
          fib_result   <= fib64(int'(stub_n)) & 64'hFFFF_FFFF;
          fib_overflow <= (fib64(int'(stub_n)) >= 64'h1_0000_0000);
          stub_busy    <= 1'b0;
        end else begin
          stub_lat <= stub_lat - 3'd1;
        end
      end
    end
  end

  // Response and go monitors, sampled mid-low-phase so the values seen are
  // the ones the next rising edge acts on
  typedef struct {
    logic [IW-1:0] n;
    logic [OW-1:0] res;
    logic          ovf;
    logic          tmo;
  } resp_t;

  resp_t resp_q[$];
  int    go_cnt;
  int    go_wide;
  int    go_with_valid;
  logic  prev_go;

  initial begin
    go_cnt        = 0;
    go_wide       = 0;
    go_with_valid = 0;
    prev_go       = 1'b0;
  end

  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      resp_t r;
      r.n   = out_n;
      r.res = out_result;
      r.ovf = out_overflow;
      r.tmo = out_timeout;
      resp_q.push_back(r);
    end
    if (fib_go) begin
      go_cnt++;
      if (prev_go) go_wide++;
      if (out_valid) go_with_valid++;
    end
    prev_go = fib_go;
  end

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] n);
    int t;
    in_valid = 1'b1;
    in_n     = n;
    t        = 0;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("push_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int k, input string name);
    int t;
    t = 0;
    while (resp_q.size() < k && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (resp_q.size() < k) check(name, 64'(resp_q.size()), 64'(k));
  endtask

  task automatic check_resp(input string name, input logic [IW-1:0] n,
                            input logic [OW-1:0] res, input logic ovf, input logic tmo);
    resp_t r;
    if (resp_q.size() == 0) begin
      check({name, "_missing"}, 64'd0, 64'd1);
    end else begin
      r = resp_q.pop_front();
      check({name, "_n"}, 64'(r.n), 64'(n));
      check({name, "_result"}, 64'(r.res), 64'(res));
      check({name, "_overflow"}, 64'(r.ovf), 64'(ovf));
      check({name, "_timeout"}, 64'(r.tmo), 64'(tmo));
    end
  endtask

  typedef struct {
    logic [IW-1:0] n;
    logic [OW-1:0] res;
    logic          ovf;
  } vec_t;

  vec_t vecs[8];
  int   full_n[6];
  int   full_res[5];
  int   full_rdy[6];
  int   go_base;
  int   t;
  logic seen_low;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{n: 6'd10, res: 32'd55,         ovf: 1'b0};
    vecs[1] = '{n: 6'd0,  res: 32'd0,          ovf: 1'b0};
    vecs[2] = '{n: 6'd1,  res: 32'd1,          ovf: 1'b0};
    vecs[3] = '{n: 6'd2,  res: 32'd1,          ovf: 1'b0};
    vecs[4] = '{n: 6'd20, res: 32'd6765,       ovf: 1'b0};
    vecs[5] = '{n: 6'd47, res: 32'd2971215073, ovf: 1'b0};
    vecs[6] = '{n: 6'd48, res: 32'd512559680,  ovf: 1'b1};
    vecs[7] = '{n: 6'd5,  res: 32'd5,          ovf: 1'b0};
    full_n[0] = 3; full_n[1] = 4; full_n[2] = 5; full_n[3] = 6; full_n[4] = 7; full_n[5] = 9;
    full_res[0] = 2; full_res[1] = 3; full_res[2] = 5; full_res[3] = 8; full_res[4] = 13;
    full_rdy[0] = 1; full_rdy[1] = 1; full_rdy[2] = 1; full_rdy[3] = 1; full_rdy[4] = 1;
    full_rdy[5] = 0;

    stub_hang = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_n      = '0;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fib_go", 64'(fib_go), 64'd0);
    check("rst_fib_n", 64'(fib_n), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_overflow", 64'(out_overflow), 64'd0);
    check("rst_out_n", 64'(out_n), 64'd0);
    check("rst_out_timeout", 64'(out_timeout), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single request with latency checks: accepted in T, go in T+2
    in_valid = 1'b1;
    in_n     = vecs[0].n;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_go_t1", 64'(fib_go), 64'd0);
    @(negedge clk);
    check("lat_go_t2", 64'(fib_go), 64'd1);
    check("lat_fib_n", 64'(fib_n), 64'(vecs[0].n));
    seen_low = 1'b0;
    t = 0;
    while (!(seen_low && fib_done) && t < 100) begin
      @(negedge clk);
      if (!fib_done) seen_low = 1'b1;
      t++;
    end
    check("done_rise_seen", 64'(seen_low && fib_done), 64'd1);
    check("valid_same_as_done", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("valid_after_done", 64'(out_valid), 64'd1);
    wait_resp(1, "single_wait");
    check_resp("single", vecs[0].n, vecs[0].res, vecs[0].ovf, 1'b0);

    // Back-to-back burst of four requests
    go_base = go_cnt;
    for (int i = 1; i <= 4; i++) push(vecs[i].n);
    wait_resp(4, "burst_wait");
    for (int i = 1; i <= 4; i++) check_resp("burst", vecs[i].n, vecs[i].res, vecs[i].ovf, 1'b0);
    repeat (5) @(negedge clk);
    check("burst_go_count", 64'(go_cnt - go_base), 64'd4);

    // Largest non-overflowing n, then first overflowing n
    for (int i = 5; i <= 6; i++) begin
      push(vecs[i].n);
      wait_resp(1, "ovf_wait");
      check_resp("ovf", vecs[i].n, vecs[i].res, vecs[i].ovf, 1'b0);
    end
    repeat (5) @(negedge clk);

    // FIFO full with output stalled: 1 in flight + 4 queued, 6th refused
    out_ready = 1'b0;
    go_base   = go_cnt;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_n     = IW'(full_n[i]);
      check("full_in_ready", 64'(in_ready), 64'(full_rdy[i]));
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("stall_go_count", 64'(go_cnt - go_base), 64'd1);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_out_n", 64'(out_n), 64'd3);
    check("stall_out_result", 64'(out_result), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_no_resp", 64'(resp_q.size()), 64'd0);
    out_ready = 1'b1;
    wait_resp(5, "full_wait");
    for (int i = 0; i < 5; i++)
      check_resp("full", IW'(full_n[i]), OW'(full_res[i]), 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("full_6th_dropped", 64'(resp_q.size()), 64'd0);

    // Reset while waiting for done
    push(6'd30);
    t = 0;
    while (!fib_go && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rstmid_go_seen", 64'(fib_go), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_fib_go", 64'(fib_go), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    rst     = 1'b1;
    go_base = go_cnt;
    repeat (20) @(negedge clk);
    check("rstmid_fifo_empty_go", 64'(go_cnt - go_base), 64'd0);
    check("rstmid_no_resp", 64'(resp_q.size()), 64'd0);
    push(vecs[7].n);
    wait_resp(1, "post_rst_wait");
    check_resp("post_rst", vecs[7].n, vecs[7].res, vecs[7].ovf, 1'b0);

`ifdef FIB_SEQ_TIMEOUT_EN
    // Watchdog abort after 16 wait cycles; core never finishes
    repeat (5) @(negedge clk);
    stub_hang = 1'b1;
    push(6'd7);
    t = 0;
    while (!fib_go && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("tmo_go_seen", 64'(fib_go), 64'd1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("tmo_latency", 64'(t), 64'd17);
    wait_resp(1, "tmo_wait");
    check_resp("tmo", 6'd7, 32'd0, 1'b0, 1'b1);
    stub_hang = 1'b0;
    repeat (3) @(negedge clk);
    push(6'd10);
    wait_resp(1, "after_tmo_wait");
    check_resp("after_tmo", 6'd10, 32'd55, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("go_single_cycle", 64'(go_wide), 64'd0);
    check("go_never_with_valid", 64'(go_with_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
